// File: rtl/pixel_window_loader.sv
// Multi-lane frame loader that buffers one IMG_W x IMG_H image and then streams
// zero-padded 3x3 neighbourhood windows in raster order under valid/ready.
module pixel_window_loader #(
  parameter int PIX_W = 5,
  parameter int LANES = 5,
  parameter int IMG_W = 20,
  parameter int IMG_H = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*PIX_W-1:0]     pixel_in,
  input  logic                       in_valid,
  input  logic                       load_end,
  output logic                       in_ready,
  output logic [9*PIX_W-1:0]         win_out,
  output logic                       win_valid,
  input  logic                       out_ready,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       readable,
  output logic                       done,
  output logic                       overflow
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int IW   = $clog2(NPIX);
  localparam int AW   = $clog2(NPIX + 1);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [AW-1:0]      wr_cnt_r;
  logic [PIX_W-1:0]   frame_r [NPIX];
  logic [RW-1:0]      row_r, pos_row_s;
  logic [CW-1:0]      col_r, pos_col_s;
  logic [9*PIX_W-1:0] win_out_r, win_nxt_s;
  logic               win_valid_r, in_ready_r, readable_r, done_r, overflow_r;
  logic               full_s, accept_s, wr_en_s, hs_s, last_s;
  logic [AW-1:0]      base_s;

  assign full_s   = (wr_cnt_r == AW'(NPIX));
  assign accept_s = in_valid & in_ready_r;
  assign wr_en_s  = accept_s & ~full_s;
  assign hs_s     = win_valid_r & out_ready;
  assign last_s   = (row_r == RW'(IMG_H - 1)) && (col_r == CW'(IMG_W - 1));

  assign in_ready  = in_ready_r;
  assign win_out   = win_out_r;
  assign win_valid = win_valid_r;
  assign win_row   = row_r;
  assign win_col   = col_r;
  assign readable  = readable_r;
  assign done      = done_r;
  assign overflow  = overflow_r;

  // Next-state decode for the load / scan sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = load_end ? ST_SCAN : ST_LOAD;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (full_s)                    state_nxt_s = ST_SCAN;
        else if (in_valid && load_end) state_nxt_s = ST_SCAN;
        else                           state_nxt_s = ST_LOAD;
      end
      ST_SCAN: begin
        if (hs_s && last_s) state_nxt_s = ST_DONE;
        else                state_nxt_s = ST_SCAN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state, write counter and status flags (flags mirror the next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wr_cnt_r   <= AW'(0);
      overflow_r <= 1'b0;
      in_ready_r <= 1'b1;
      readable_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD);
      readable_r <= (state_nxt_s == ST_SCAN);
      done_r     <= (state_nxt_s == ST_DONE);
      if (state_r == ST_DONE) wr_cnt_r <= AW'(0);
      else if (wr_en_s)       wr_cnt_r <= wr_cnt_r + AW'(LANES);
      if (accept_s && full_s) overflow_r <= 1'b1;
    end
  end

  // Frame buffer: one LANES-wide beat written per accepted, non-full handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPIX; i++) frame_r[i] <= PIX_W'(0);
    end else if (wr_en_s) begin
      for (int l = 0; l < LANES; l++)
        frame_r[IW'(wr_cnt_r + AW'(l))] <= pixel_in[l*PIX_W +: PIX_W];
    end
  end

  // Position of the window being fetched: current on first fetch, else the raster successor.
  always_comb begin
    pos_row_s = row_r;
    pos_col_s = col_r;
    if (win_valid_r) begin
      if (col_r == CW'(IMG_W - 1)) begin
        pos_col_s = CW'(0);
        pos_row_s = row_r + RW'(1);
      end else begin
        pos_col_s = col_r + CW'(1);
      end
    end else begin
      pos_row_s = row_r;
      pos_col_s = col_r;
    end
  end

  assign base_s = AW'(pos_row_s) * AW'(IMG_W) + AW'(pos_col_s);

  // Each tap is masked by the image border and by the loaded extent, so stale
  // pixels from an earlier, longer frame never leak into a short frame.
  for (genvar g = 0; g < 9; g++) begin : g_tap
    localparam int DR = g / 3 - 1;
    localparam int DC = g % 3 - 1;
    logic          row_ok_s, col_ok_s;
    logic [AW-1:0] addr_s;

    if (DR < 0)      begin : g_ru assign row_ok_s = (pos_row_s != RW'(0));         end
    else if (DR > 0) begin : g_rd assign row_ok_s = (pos_row_s < RW'(IMG_H - 1));  end
    else             begin : g_rc assign row_ok_s = 1'b1;                          end
    if (DC < 0)      begin : g_cl assign col_ok_s = (pos_col_s != CW'(0));         end
    else if (DC > 0) begin : g_cr assign col_ok_s = (pos_col_s < CW'(IMG_W - 1));  end
    else             begin : g_cc assign col_ok_s = 1'b1;                          end

    assign addr_s = base_s + AW'(DR * IMG_W + DC);
    assign win_nxt_s[g*PIX_W +: PIX_W] =
      (row_ok_s && col_ok_s && (addr_s < wr_cnt_r)) ? frame_r[addr_s[IW-1:0]] : PIX_W'(0);
  end

  // Window output register: first fetch on SCAN entry, advance on handshake, hold on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid_r <= 1'b0;
      win_out_r   <= '0;
      row_r       <= RW'(0);
      col_r       <= CW'(0);
    end else if (state_r == ST_SCAN) begin
      if (!win_valid_r) begin
        win_valid_r <= 1'b1;
        win_out_r   <= win_nxt_s;
        row_r       <= pos_row_s;
        col_r       <= pos_col_s;
      end else if (out_ready) begin
        if (last_s) begin
          win_valid_r <= 1'b0;
          row_r       <= RW'(0);
          col_r       <= CW'(0);
        end else begin
          win_out_r <= win_nxt_s;
          row_r     <= pos_row_s;
          col_r     <= pos_col_s;
        end
      end
    end else begin
      win_valid_r <= 1'b0;
      win_out_r   <= '0;
      row_r       <= RW'(0);
      col_r       <= CW'(0);
    end
  end

endmodule

// File: tb/tb_pixel_window_loader.sv
// Directed bench for pixel_window_loader: closed-form window model, a table of
// hand-computed windows, and sequences for stall, short load, overflow and reset.
module tb_pixel_window_loader;

  localparam int PIX_W = 5;
  localparam int LANES = 5;
  localparam int IMG_W = 20;
  localparam int IMG_H = 20;
  localparam int NPIX  = IMG_W * IMG_H;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [LANES*PIX_W-1:0]   pixel_in;
  logic                     in_valid, load_end, in_ready;
  logic [9*PIX_W-1:0]       win_out;
  logic                     win_valid, out_ready;
  logic [4:0]               win_row, win_col;
  logic                     readable, done, overflow;

  always #5 clk = ~clk;

  pixel_window_loader #(.PIX_W(PIX_W), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .load_end(load_end),
    .in_ready(in_ready), .win_out(win_out), .win_valid(win_valid), .out_ready(out_ready),
    .win_row(win_row), .win_col(win_col), .readable(readable), .done(done), .overflow(overflow)
  );

  typedef struct {
    int          scen;
    int          r;
    int          c;
    logic [44:0] win;
  } tv_t;

  tv_t         tv [6];
  logic [44:0] cap [NPIX];
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_nvalid;
  int          nwin, done_cnt, done_at;
  string       cur_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  function automatic logic [44:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {5'(a8), 5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Pixel k of the loaded stream carries value k mod 32.
  function automatic logic [44:0] model_win(input int r, input int c);
    logic [44:0] w;
    int rr, cc, k;
    w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        k  = rr * IMG_W + cc;
        if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W && k < model_nvalid)
          w[((dr + 1) * 3 + (dc + 1)) * 5 +: 5] = 5'(k % 32);
      end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int nbeats, input int le_beat);
    for (int b = 1; b <= nbeats; b++) begin
      for (int l = 0; l < LANES; l++) pixel_in[l*PIX_W +: PIX_W] = 5'(((b - 1) * LANES + l) % 32);
      in_valid = 1'b1;
      load_end = (b == le_beat);
      step();
    end
    in_valid = 1'b0;
    load_end = 1'b0;
    pixel_in = '0;
  endtask

  // Cycle 0 is the first cycle in SCAN. mode 0: out_ready always high; mode 1:
  // out_ready follows 1,0,0,1 and junk beats are offered throughout the scan.
  task automatic run_scan(input int mode);
    logic        held_v;
    logic [55:0] held;
    int          er, ec;
    bit          seq_ok, finished;
    chk("scan_readable", readable, 1);
    chk("scan_in_ready", in_ready, 0);
    nwin = 0; done_cnt = 0; done_at = -1; held_v = 1'b0; seq_ok = 1'b1; finished = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (held_v) chk("stall_hold", {win_valid, 5'(win_row), 5'(win_col), win_out}, held);
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      in_valid  = (mode == 1) && (done_at < 0) && !done;
      pixel_in  = (mode == 1) ? 25'h1FF_FFFF : 25'h000_0000;
      held_v = 1'b0;
      if (win_valid) begin
        if (out_ready) begin
          er = nwin / IMG_W;
          ec = nwin % IMG_W;
          if (nwin >= NPIX || win_row != 5'(er) || win_col != 5'(ec)) seq_ok = 1'b0;
          else begin
            cap[nwin] = win_out;
            chk("window", win_out, model_win(er, ec));
          end
          nwin++;
        end else begin
          held_v = 1'b1;
          held   = {1'b1, 5'(win_row), 5'(win_col), win_out};
        end
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 4) finished = 1'b1;
      else step();
    end
    in_valid = 1'b0;
    pixel_in = '0;
    chk("scan_finished", finished, 1);
    chk("window_count", nwin, NPIX);
    chk("raster_order", seq_ok, 1);
    chk("done_once", done_cnt, 1);
    chk("post_in_ready", in_ready, 1);
    chk("post_readable", readable, 0);
    chk("post_win_valid", win_valid, 0);
  endtask

  task automatic check_table(input int scen);
    for (int i = 0; i < 6; i++)
      if (tv[i].scen == scen)
        chk($sformatf("tbl_r%0d_c%0d", tv[i].r, tv[i].c), cap[tv[i].r * IMG_W + tv[i].c], tv[i].win);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_readable", readable, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_win_out", win_out, 0);
    chk("rst_row_col", {win_row, win_col}, 0);
  endtask

  initial begin
    bit hit, done_seen;
    // Full load: values are pixel index mod 32 (e.g. pixel 378 -> 26, 398 -> 14, 399 -> 15).
    tv[0] = '{0, 0, 0,   pack9(0, 0, 0, 0, 0, 1, 0, 20, 21)};
    tv[1] = '{0, 1, 1,   pack9(0, 1, 2, 20, 21, 22, 8, 9, 10)};
    tv[2] = '{0, 19, 19, pack9(26, 27, 0, 14, 15, 0, 0, 0, 0)};
    tv[3] = '{0, 0, 19,  pack9(0, 0, 0, 18, 19, 0, 6, 7, 0)};
    // 40-pixel load: rows 0-1 hold data, everything below reads 0.
    tv[4] = '{2, 2, 0,   pack9(0, 20, 21, 0, 0, 0, 0, 0, 0)};
    tv[5] = '{2, 1, 0,   pack9(0, 0, 1, 0, 20, 21, 0, 0, 0)};

    reset = 1'b1; in_valid = 1'b0; load_end = 1'b0; out_ready = 1'b0; pixel_in = '0;
    step(); step();
    reset = 1'b0;
    step();
    cur_tag = "reset";
    check_reset_outputs();

    cur_tag = "full";
    model_nvalid = NPIX;
    load_frame(80, 80);
    chk("no_overflow", overflow, 0);
    run_scan(0);
    // done lands in the 402nd cycle counting the SCAN-entry cycle as the first.
    chk("done_latency", done_at, 401);
    check_table(0);

    cur_tag = "stall";
    load_frame(80, 80);
    run_scan(1);
    chk("scan_beats_ignored", overflow, 0);

    cur_tag = "short";
    model_nvalid = 40;
    load_frame(8, 8);
    run_scan(0);
    check_table(2);

    cur_tag = "overflow";
    model_nvalid = NPIX;
    load_frame(81, 0);
    chk("ovf_set", overflow, 1);
    run_scan(0);
    chk("ovf_sticky", overflow, 1);

    cur_tag = "midreset";
    load_frame(80, 80);
    out_ready = 1'b1;
    hit = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (win_valid && win_row == 5'd5 && win_col == 5'd3) hit = 1'b1;
      else step();
    end
    chk("reached_5_3", hit, 1);
    chk("ovf_before_reset", overflow, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_seen = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) done_seen = 1'b1;
    end
    chk("no_done_after_abort", done_seen, 0);
    check_reset_outputs();

    cur_tag = "reload";
    load_frame(80, 80);
    run_scan(0);
    chk("done_latency", done_at, 401);
    check_table(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
